// File: rtl/mac_seq.sv
// Sequential signed multiply-accumulate engine: takes a job of len (A,X) pairs,
// folds each pair into acc with a halving MAC step, then presents the result.
module mac_seq #(
   parameter int N  = 32,
   parameter int LW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [LW-1:0] len,
   input  logic [N-1:0]  y_init,
   input  logic          abort,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_a,
   input  logic [N-1:0]  in_x,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_y,
   output logic          busy,
   output logic [LW-1:0] count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state, state_n;
   logic [N-1:0]  acc, acc_n;
   logic [LW-1:0] cnt, cnt_n;
   logic [LW-1:0] len_q, len_n;

   logic [2*N-1:0] a_ext, x_ext, prod;
   logic [N-1:0]   h;
   logic [N:0]     s;
   logic [N-1:0]   f;
   logic [LW-1:0]  cnt_inc;

   // Both operands sign-extended to 2N so the low 2N bits of the product are exact.
   always_comb begin
      a_ext = {{N{in_a[N-1]}}, in_a};
      x_ext = {{N{in_x[N-1]}}, in_x};
      prod  = a_ext * x_ext;
      h     = prod[2*N-1:N];
      s     = {h[N-1], h} + {acc[N-1], acc};
      f     = s[N:1];
   end

   assign cnt_inc   = cnt + 1'b1;
   assign in_ready  = (state == RUN) && !abort;
   assign out_valid = (state == DONE);
   assign out_y     = acc;
   assign busy      = (state != IDLE);
   assign count     = cnt;

   always_comb begin
      state_n = state;
      acc_n   = acc;
      cnt_n   = cnt;
      len_n   = len_q;
      case (state)
         IDLE: begin
            if (start) begin
               len_n   = len;
               acc_n   = y_init;
               cnt_n   = '0;
               state_n = (len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (in_valid && in_ready) begin
               acc_n = f;
               cnt_n = cnt_inc;
               if (cnt_inc == len_q) state_n = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      // abort overrides whatever the state case decided, including an IDLE start
      if (abort) begin
         state_n = IDLE;
         cnt_n   = '0;
         acc_n   = (state == IDLE) ? acc : acc_n;
         len_n   = (state == IDLE) ? len_q : len_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
         len_q <= '0;
      end else begin
         state <= state_n;
         acc   <= acc_n;
         cnt   <= cnt_n;
         len_q <= len_n;
      end
   end

endmodule

// File: tb/tb_mac_seq.sv
// Scoreboard bench for mac_seq: stimulus pushes reference results computed with
// plain 64-bit arithmetic; a monitor pops and compares on every output handshake.
module tb_mac_seq;
   localparam int N  = 32;
   localparam int LW = 5;

   logic          clk = 1'b0;
   logic          rst, start, abort, in_valid, out_ready;
   logic [LW-1:0] len;
   logic [N-1:0]  y_init, in_a, in_x;
   logic          in_ready, out_valid, busy;
   logic [N-1:0]  out_y;
   logic [LW-1:0] count;

   always #5 clk = ~clk;

   mac_seq #(.N(N), .LW(LW)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .y_init(y_init),
      .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_x(in_x), .out_valid(out_valid), .out_ready(out_ready),
      .out_y(out_y), .busy(busy), .count(count)
   );

   typedef struct packed {
      logic [N-1:0]  y;
      logic [LW-1:0] c;
   } exp_t;

   exp_t sbq[$];
   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // y' = ((a*x >> N) + y) >> 1, all values read as signed integers
   function automatic logic [N-1:0] mac_ref(input logic [N-1:0] a, input logic [N-1:0] x,
                                            input logic [N-1:0] y);
      longint p, s;
      p = longint'($signed(a)) * longint'($signed(x));
      s = (p >>> N) + longint'($signed(y));
      return s[N:1];
   endfunction

   function automatic logic [N-1:0] rnd_op();
      case ($urandom_range(0, 7))
         0: return 32'h8000_0000;
         1: return 32'h7FFF_FFFF;
         2: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         exp_t e;
         if (sbq.size() == 0) check("sb_unexpected_output", 1, 0);
         else begin
            e = sbq.pop_front();
            check("sb_out_y", out_y, e.y);
            check("sb_count", count, e.c);
         end
      end
   end

   task automatic run_job(input int l, input logic [N-1:0] yi, input bit use_fixed,
                          input logic [N-1:0] fa, input logic [N-1:0] fx,
                          input int maxgap, input int bpcyc, input bit hs_start);
      logic [N-1:0] a[$], x[$], run[$];
      logic [N-1:0] y;
      exp_t e;
      y = yi;
      for (int i = 0; i < l; i++) begin
         a.push_back(use_fixed ? fa : rnd_op());
         x.push_back(use_fixed ? fx : rnd_op());
         y = mac_ref(a[i], x[i], y);
         run.push_back(y);
      end
      e.y = y;
      e.c = l[LW-1:0];
      sbq.push_back(e);

      start = 1'b1; len = l[LW-1:0]; y_init = yi;
      @(posedge clk); #1;
      start = 1'b0; len = LW'($urandom); y_init = $urandom;
      check("busy_after_start", busy, 1);
      for (int i = 0; i < l; i++) begin
         repeat ($urandom_range(0, maxgap)) begin
            in_valid = 1'b0; in_a = $urandom; in_x = $urandom;
            @(posedge clk); #1;
            check("gap_hold_count", count, i);
         end
         in_valid = 1'b1; in_a = a[i]; in_x = x[i];
         check("in_ready_run", in_ready, 1);
         @(posedge clk); #1;
         in_valid = 1'b0;
         check("count_step", count, i + 1);
         check("acc_step", out_y, run[i]);
      end
      if (l == 0) check("in_ready_len0", in_ready, 0);
      check("latency_out_valid", out_valid, 1);
      for (int k = 0; k < bpcyc; k++) begin
         out_ready = 1'b0;
         start = (k == 1);
         check("bp_out_valid", out_valid, 1);
         check("bp_out_y", out_y, y);
         @(posedge clk); #1;
         start = 1'b0;
      end
      out_ready = 1'b1; start = hs_start;
      @(posedge clk); #1;
      out_ready = 1'b0; start = 1'b0;
      check("idle_after_hs", {busy, out_valid}, 2'b00);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      len = '0; y_init = '0; in_a = '0; in_x = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_out_y", out_y, 0);
      check("rst_count", count, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // directed jobs
      run_job(1, 32'h0, 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0, 0);
      check("single_pair_ref", mac_ref(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0), 32'h1FFF_FFFF);
      run_job(2, 32'h7FFF_FFFF, 1, 32'h4000_0000, 32'h4000_0000, 0, 0, 0);
      run_job(0, 32'd5, 0, '0, '0, 0, 0, 0);
      run_job(2, $urandom, 0, '0, '0, 2, 3, 1);
      run_job(31, $urandom, 0, '0, '0, 1, 1, 0);

      for (int j = 0; j < 25; j++)
         run_job($urandom_range(0, 31), rnd_op(), 0, '0, '0,
                 $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 1));

      // reset mid-job after one pair
      start = 1'b1; len = 5'd3; y_init = $urandom;
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b1; in_a = $urandom; in_x = $urandom;
      @(posedge clk); #1;
      check("pre_rst_count", count, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midjob_rst", {busy, in_ready, out_valid, count, out_y}, '0);
      rst = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;

      // abort on the second pair handshake
      out_ready = 1'b1;
      start = 1'b1; len = 5'd3; y_init = $urandom;
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b1; in_a = $urandom; in_x = $urandom;
      @(posedge clk); #1;
      check("abort_pre_count", count, 1);
      abort = 1'b1;
      #1;
      check("abort_in_ready", in_ready, 0);
      @(posedge clk); #1;
      abort = 1'b0; in_valid = 1'b0;
      check("abort_idle", {busy, count}, '0);
      repeat (4) begin
         check("abort_no_output", out_valid, 0);
         @(posedge clk); #1;
      end

      // abort simultaneous with start keeps the block idle
      start = 1'b1; abort = 1'b1; len = 5'd2;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      check("abort_beats_start", busy, 0);
      out_ready = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("sb_empty", sbq.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
